demux_1to4_reg: RTL and testbench

DEMUX_1TO4_REG -- requirements
Module: demux_1to4_reg

---
 rtl/demux_pkg.sv | 6 +
 rtl/demux_lane_reg.sv | 45 ++++
 rtl/demux_1to4_reg.sv | 93 +++++++++
 tb/tb_demux_1to4_reg.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer.
package demux_pkg;
  localparam int unsigned N_LANES = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned CNT_W   = 8;
endpackage : demux_pkg

// File: rtl/demux_lane_reg.sv
// One-entry output lane register with load, drain and synchronous flush.
module demux_lane_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  // Flush wins; a load always refills, so a same-cycle drain+load keeps the lane full.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule : demux_lane_reg

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer with per-lane handshake and transfer counter.
// Define DEMUX_RR_EN to enable round-robin lane selection when rr=1.
module demux_1to4_reg
  import demux_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     s,
  input  logic                 rr,
  input  logic                 flush,
  output logic [N_LANES*W-1:0] y,
  output logic [N_LANES-1:0]   y_valid,
  input  logic [N_LANES-1:0]   y_ready,
  output logic [CNT_W-1:0]     xfer_cnt
);

  logic [SEL_W-1:0]   tgt;
  logic               xfer;
  logic [N_LANES-1:0] lane_load;
  logic [N_LANES-1:0] lane_drain;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

`ifdef DEMUX_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;

  // Pointer returns to lane 0 on flush and advances only on round-robin transfers.
  always_comb begin
    ptr_d = ptr_q;
    if (flush) begin
      ptr_d = '0;
    end else if (xfer && rr) begin
      ptr_d = ptr_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign tgt = rr ? ptr_q : s;
`else
  logic unused_rr;
  assign unused_rr = rr;
  assign tgt       = s;
`endif

  // Only the target lane's occupancy gates acceptance.
  assign in_ready = !flush && (!y_valid[tgt] || y_ready[tgt]);
  assign xfer     = in_valid && in_ready;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    assign lane_load[k]  = xfer && (tgt == SEL_W'(k));
    assign lane_drain[k] = y_valid[k] && y_ready[k];

    demux_lane_reg #(.W(W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .load_i  (lane_load[k]),
      .drain_i (lane_drain[k]),
      .data_i  (in),
      .data_o  (y[k*W +: W]),
      .valid_o (y_valid[k])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;

endmodule : demux_1to4_reg

// File: tb/tb_demux_1to4_reg.sv
// Directed, table-driven bench for demux_1to4_reg; round-robin checks need DEMUX_RR_EN.
module tb_demux_1to4_reg;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   s;
  logic         rr;
  logic         flush;
  logic [4*W-1:0] y;
  logic [3:0]   y_valid;
  logic [3:0]   y_ready;
  logic [7:0]   xfer_cnt;

  int checks = 0;
  int errors = 0;

  demux_1to4_reg #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s        (s),
    .rr       (rr),
    .flush    (flush),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [1:0] sel;
    logic [7:0] d;
    logic [3:0] yr;
    logic       fl;
    logic       exp_rdy;
    logic [3:0] exp_yv;
    logic [7:0] exp_cnt;
    int         lane;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lane_y(input int k);
    return y[k*W +: W];
  endfunction

  task automatic send(input logic iv, input logic [1:0] sel, input logic rrv,
                      input logic [7:0] d, input logic [3:0] yr, input logic fl);
    in_valid = iv; s = sel; rr = rrv; din = d; y_ready = yr; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lane(input string name, input int k, input logic [7:0] d, input logic [7:0] cnt);
    chk({name, " yv"}, 32'(y_valid), 32'(4'b0001 << k));
    chk({name, " data"}, 32'(lane_y(k)), 32'(d));
    chk({name, " cnt"}, 32'(xfer_cnt), 32'(cnt));
  endtask

  initial begin
    // iv  sel   d      yr      fl    rdy   yv       cnt  lane data
    tbl[0]  = '{1'b1, 2'd0, 8'h11, 4'b1111, 1'b0, 1'b1, 4'b0001, 8'd1,  0, 8'h11};
    tbl[1]  = '{1'b1, 2'd1, 8'h22, 4'b1111, 1'b0, 1'b1, 4'b0010, 8'd2,  1, 8'h22};
    tbl[2]  = '{1'b1, 2'd2, 8'h33, 4'b1111, 1'b0, 1'b1, 4'b0100, 8'd3,  2, 8'h33};
    tbl[3]  = '{1'b1, 2'd3, 8'h44, 4'b1111, 1'b0, 1'b1, 4'b1000, 8'd4,  3, 8'h44};
    tbl[4]  = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 1'b1, 4'b0000, 8'd4,  0, 8'h00};
    tbl[5]  = '{1'b1, 2'd2, 8'h55, 4'b1011, 1'b0, 1'b1, 4'b0100, 8'd5,  2, 8'h55};
    tbl[6]  = '{1'b1, 2'd2, 8'h66, 4'b1011, 1'b0, 1'b0, 4'b0100, 8'd5,  2, 8'h55};
    tbl[7]  = '{1'b1, 2'd2, 8'h66, 4'b1111, 1'b0, 1'b1, 4'b0100, 8'd6,  2, 8'h66};
    tbl[8]  = '{1'b1, 2'd0, 8'h77, 4'b1011, 1'b0, 1'b1, 4'b0101, 8'd7,  0, 8'h77};
    tbl[9]  = '{1'b0, 2'd2, 8'h00, 4'b0000, 1'b0, 1'b0, 4'b0101, 8'd7,  2, 8'h66};
    tbl[10] = '{1'b1, 2'd1, 8'h88, 4'b1111, 1'b1, 1'b0, 4'b0000, 8'd7,  0, 8'h00};
    tbl[11] = '{1'b1, 2'd1, 8'h99, 4'b0000, 1'b0, 1'b1, 4'b0010, 8'd8,  1, 8'h99};
    tbl[12] = '{1'b1, 2'd3, 8'hAA, 4'b0000, 1'b0, 1'b1, 4'b1010, 8'd9,  3, 8'hAA};
    tbl[13] = '{1'b1, 2'd1, 8'hBB, 4'b0010, 1'b0, 1'b1, 4'b1010, 8'd10, 1, 8'hBB};

    rst = 1'b1; din = '0; in_valid = 1'b0; s = '0; rr = 1'b0; flush = 1'b0; y_ready = '0;
    #1;
    chk("reset yv", 32'(y_valid), 32'h0);
    chk("reset y", y, 32'h0);
    chk("reset cnt", 32'(xfer_cnt), 32'h0);
    chk("reset rdy", 32'(in_ready), 32'h1);
    flush = 1'b1;
    #1;
    chk("reset rdy flush", 32'(in_ready), 32'h0);
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      in_valid = tbl[i].iv; s = tbl[i].sel; din = tbl[i].d;
      y_ready = tbl[i].yr; flush = tbl[i].fl; rr = 1'b0;
      #1;
      chk($sformatf("v%0d rdy", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d yv", i), 32'(y_valid), 32'(tbl[i].exp_yv));
      chk($sformatf("v%0d cnt", i), 32'(xfer_cnt), 32'(tbl[i].exp_cnt));
      if (tbl[i].exp_yv[tbl[i].lane])
        chk($sformatf("v%0d data", i), 32'(lane_y(tbl[i].lane)), 32'(tbl[i].exp_data));
    end

    // Asynchronous reset between edges while lanes 1 and 3 hold words.
    in_valid = 1'b0; flush = 1'b0; y_ready = 4'b0000;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst yv", 32'(y_valid), 32'h0);
    chk("midrst y", y, 32'h0);
    chk("midrst cnt", 32'(xfer_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;

`ifdef DEMUX_RR_EN
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 2'd3, 1'b1, 8'hA0 + 8'(i), 4'b1111, 1'b0);
      chk_lane($sformatf("rr%0d", i), i % 4, 8'hA0 + 8'(i), 8'(i + 1));
    end
    send(1'b1, 2'd3, 1'b0, 8'hB0, 4'b1111, 1'b0);
    chk_lane("rr hold manual", 3, 8'hB0, 8'd6);
    send(1'b1, 2'd3, 1'b1, 8'hB1, 4'b1111, 1'b0);
    chk_lane("rr hold resume", 1, 8'hB1, 8'd7);
    send(1'b1, 2'd3, 1'b1, 8'hB2, 4'b0000, 1'b1);
    chk("rr flush yv", 32'(y_valid), 32'h0);
    chk("rr flush cnt", 32'(xfer_cnt), 32'd7);
    send(1'b1, 2'd3, 1'b1, 8'hB3, 4'b1111, 1'b0);
    chk_lane("rr after flush", 0, 8'hB3, 8'd8);
`else
    send(1'b1, 2'd2, 1'b1, 8'hC0, 4'b1111, 1'b0);
    chk_lane("rr ignored", 2, 8'hC0, 8'd1);
    send(1'b1, 2'd1, 1'b1, 8'hC1, 4'b1111, 1'b0);
    chk_lane("rr ignored2", 1, 8'hC1, 8'd2);
`endif

    // Counter wrap from a fresh reset: 256 back-to-back transfers into lane 0.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 255; i++) send(1'b1, 2'd0, 1'b0, 8'(i), 4'b1111, 1'b0);
    chk("cnt 255", 32'(xfer_cnt), 32'd255);
    chk("cnt 255 data", 32'(lane_y(0)), 32'd254);
    send(1'b1, 2'd0, 1'b0, 8'hFF, 4'b1111, 1'b0);
    chk("cnt wrap", 32'(xfer_cnt), 32'd0);
    chk("cnt wrap yv", 32'(y_valid), 32'h1);
    send(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b0);
    chk("drain idle yv", 32'(y_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_demux_1to4_reg
